reg_mux_stage: RTL and testbench
================================

Name: reg_mux_stage

Overview:
- Generic datapath primitive stage built from three codebase primitives:
  - a binary-select word multiplexer (gmux behaviour);
  - a clock-enabled register with synchronous reset to an init value (r behaviour);
  - a chain of plain one-cycle delay flops (d1 behaviour).
- Used wherever one of several packed words must be selected, captured under enable, and its registered value also delivered with extra pipeline latency for timing. Examples: token selection, frame counters, power-enable retiming.

Parameters:
- DWIDTH, 19, width of each data word.
- SELWIDTH, 2, select width; number of input words N = 2**SELWIDTH.
- INIT, 0 (DWIDTH bits), value loaded into q on reset.
- DELAY, 3, number of d1 stages between q and q_d; legal range 0..16.

Ports:
- c  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  capture enable for q.
- d  input  DWIDTH*N  packed input words; word i = d[i*DWIDTH +: DWIDTH], word 0 in LSBs.
- sel  input  SELWIDTH  word select.
- z  output  DWIDTH  combinational mux output.
- q  output  DWIDTH  registered output.
- q_d  output  DWIDTH  q delayed by DELAY cycles.

Behaviour:
- Interface: one clock (c); reset rst is synchronous and active-high.
- Mux:
  - z = d[sel*DWIDTH +: DWIDTH], purely combinational, zero latency.
  - Every sel value addresses a valid word, so there is no out-of-range case.
  - Changing sel changes z in the same cycle.
- Register q, evaluated at each rising edge of c:
  - rst=1: q <= INIT, regardless of en (rst has priority over en).
  - rst=0, en=1: q <= z (value of z sampled at that edge).
  - rst=0, en=0: q holds.
  - Reset value of q is INIT; q is visible on the cycle after the reset edge.
  - rst asserted mid-operation overrides any capture in that cycle.
  - Deasserting rst with en=1 captures z on the first non-reset edge.
- Delay chain:
  - DELAY stages s1..sDELAY; each edge: s1 <= q, s(k+1) <= s(k); q_d = sDELAY.
  - Stages have no enable and shift every cycle, independent of en.
  - DELAY=0: q_d = q (wire, no flops).
  - Latency from a capture edge to q_d change is DELAY cycles beyond q.
- Delay-stage reset (base build):
  - Delay stages ignore rst; power-up value is INIT via register initialisation.
  - After rst, q_d shows INIT only once the chain has flushed (DELAY cycles after q goes to INIT).
- Arithmetic: none inside the block. Incrementers and other datapath logic feed d externally; wrap-around is the caller's concern.
- All outputs are fully determined after DELAY cycles of reset; no X outputs after that.

Optional Feature:
- Macro: REG_MUX_STAGE_DELAY_RST_EN.
- Defined:
  - Every delay stage also resets synchronously to INIT when rst=1, with the same priority as q.
  - q_d = INIT on the first cycle after the reset edge; no flush latency.
- Undefined:
  - Base behaviour: delay stages are reset-free plain d1 flops and flush over DELAY cycles.
  - Reset-free stages are preferred for timing/packing in high-fanout retiming paths.

Test Plan:
1. Mux select: DWIDTH=19, SELWIDTH=2, d={19'h0, 19'h2AAAA, 19'h15555, 19'h0F0F0}; sweep sel 0..3 -> z = 19'h0F0F0, 19'h15555, 19'h2AAAA, 19'h0, combinationally in the same cycle.
2. Reset priority: INIT=19'h00123, rst=1 and en=1 with sel=1 for one edge -> q=19'h00123 (not 19'h15555); next edge with rst=0, en=1 -> q=19'h15555.
3. Enable hold: load q=19'h0F0F0 (sel=0, en=1); then en=0 for 10 cycles while sel toggles 1..3 -> q stays 19'h0F0F0 and z follows sel.
4. Delay latency: DELAY=3, capture 19'h2AAAA at edge N -> q changes after edge N, q_d changes after edge N+3; with DELAY=0, q_d equals q every cycle.
5. Reset flush, base build: q_d carrying 19'h2AAAA, pulse rst one cycle -> q=INIT next cycle, q_d=INIT exactly 3 cycles later. With REG_MUX_STAGE_DELAY_RST_EN -> q_d=INIT the cycle after the reset edge.
6. Counter use: feed d word 0 with q+1 externally, SELWIDTH=1, sel=0, en=1, INIT=0, DWIDTH=4 -> q counts 0..15, wraps to 0; rst at count 9 -> q=0 on next cycle.

Source files
------------

// File: rtl/reg_mux_stage_if.sv
// Bus bundle for reg_mux_stage: packed input words, select, enable and the three outputs.
// The master side drives en/d/sel; the slave (the stage itself) drives z/q/q_d.
interface reg_mux_stage_if #(
    parameter int DWIDTH   = 19,
    parameter int SELWIDTH = 2
);
    logic                               en;
    logic [DWIDTH*(2**SELWIDTH)-1:0]    d;
    logic [SELWIDTH-1:0]                sel;
    logic [DWIDTH-1:0]                  z;
    logic [DWIDTH-1:0]                  q;
    logic [DWIDTH-1:0]                  q_d;

    modport master (
        output en,
        output d,
        output sel,
        input  z,
        input  q,
        input  q_d
    );

    modport slave (
        input  en,
        input  d,
        input  sel,
        output z,
        output q,
        output q_d
    );
endinterface

// File: rtl/reg_mux_stage.sv
// Word mux -> enabled register (sync reset to INIT) -> DELAY-stage retiming chain.
// Optional macro REG_MUX_STAGE_DELAY_RST_EN: delay stages also reset to INIT.
module reg_mux_stage #(
    parameter int                DWIDTH   = 19,
    parameter int                SELWIDTH = 2,
    parameter logic [DWIDTH-1:0] INIT     = '0,
    parameter int                DELAY    = 3
) (
    input  logic            c,
    input  logic            rst,
    reg_mux_stage_if.slave  bus
);
    localparam int N = 2 ** SELWIDTH;

    logic [DWIDTH-1:0] words [N];
    logic [DWIDTH-1:0] z;
    logic [DWIDTH-1:0] q;

    // Unpack the bus so every sel value maps to exactly one word.
    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign words[i] = bus.d[i*DWIDTH +: DWIDTH];
    end

    assign z     = words[bus.sel];
    assign bus.z = z;
    assign bus.q = q;

    // NOTE: rst is tested first so a reset edge wins over a simultaneous capture.
    always_ff @(posedge c) begin
        if (rst) begin
            q <= INIT;
        end else if (bus.en) begin
            q <= z;
        end
    end

    if (DELAY == 0) begin : g_no_delay
        assign bus.q_d = q;
    end else begin : g_delay
        // Declaration value gives the power-up contents; no reset is needed in the base build.
        logic [DWIDTH-1:0] stage [DELAY] = '{default: INIT};

        always_ff @(posedge c) begin
`ifdef REG_MUX_STAGE_DELAY_RST_EN
            if (rst) begin
                for (int k = 0; k < DELAY; k++) begin
                    stage[k] <= INIT;
                end
            end else begin
                stage[0] <= q;
                for (int k = 1; k < DELAY; k++) begin
                    stage[k] <= stage[k-1];
                end
            end
`else
            stage[0] <= q;
            for (int k = 1; k < DELAY; k++) begin
                stage[k] <= stage[k-1];
            end
`endif
        end

        assign bus.q_d = stage[DELAY-1];
    end
endmodule

// File: tb/tb_reg_mux_stage.sv
// Self-checking bench for reg_mux_stage: three instances (DELAY=3, DELAY=0, 4-bit counter)
// compared against a queue-based history model of q and q_d.
module tb_reg_mux_stage;
    localparam int                DW_A    = 19;
    localparam int                SW_A    = 2;
    localparam int                DLY_A   = 3;
    localparam logic [DW_A-1:0]   INIT_A  = 19'h00123;
    localparam logic [4*DW_A-1:0] TBL     = {19'h0, 19'h2AAAA, 19'h15555, 19'h0F0F0};
    localparam int                DLY_C   = 3;

    logic c = 1'b0;
    logic rst_a;
    logic rst_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 c = ~c;

    reg_mux_stage_if #(.DWIDTH(DW_A), .SELWIDTH(SW_A)) ia ();
    reg_mux_stage_if #(.DWIDTH(DW_A), .SELWIDTH(SW_A)) ib ();
    reg_mux_stage_if #(.DWIDTH(4),    .SELWIDTH(1))    ic ();

    reg_mux_stage #(.DWIDTH(DW_A), .SELWIDTH(SW_A), .INIT(INIT_A), .DELAY(DLY_A)) u_a (
        .c(c), .rst(rst_a), .bus(ia)
    );
    reg_mux_stage #(.DWIDTH(DW_A), .SELWIDTH(SW_A), .INIT(INIT_A), .DELAY(0)) u_b (
        .c(c), .rst(rst_a), .bus(ib)
    );
    reg_mux_stage #(.DWIDTH(4), .SELWIDTH(1), .INIT(4'h0), .DELAY(DLY_C)) u_c (
        .c(c), .rst(rst_c), .bus(ic)
    );

    // Counter use: word 0 is q+1 computed outside the block.
    assign ic.d = {4'h9, ic.q + 4'd1};

    // Reference state: q value and the last DELAY values of q seen before each edge.
    logic [DW_A-1:0] qm;
    logic [DW_A-1:0] hist [$];
    int              cnt;
    int              chist [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW_A-1:0] word_at(input logic [4*DW_A-1:0] dd, input logic [1:0] s);
        logic [4*DW_A-1:0] t;
        t = dd >> (DW_A * int'(s));
        return t[DW_A-1:0];
    endfunction

    // One cycle on instances A and B: drive, check z, clock, advance model, check q/q_d.
    task automatic step(input logic r, input logic e, input logic [1:0] s, input logic [4*DW_A-1:0] dd);
        logic [DW_A-1:0] zexp;
        rst_a  = r;
        ia.en  = e;  ia.sel = s;  ia.d = dd;
        ib.en  = e;  ib.sel = s;  ib.d = dd;
        #1;
        zexp = word_at(dd, s);
        check("z", ia.z, zexp);
        check("z_dly0", ib.z, zexp);
        @(posedge c);
        hist.push_front(qm);
        void'(hist.pop_back());
`ifdef REG_MUX_STAGE_DELAY_RST_EN
        if (r) foreach (hist[k]) hist[k] = INIT_A;
`endif
        qm = r ? INIT_A : (e ? zexp : qm);
        #1;
        check("q", ia.q, qm);
        check("q_d", ia.q_d, hist[DLY_A-1]);
        check("q_dly0", ib.q, qm);
        check("q_d_dly0", ib.q_d, ib.q);
        check("q_d_dly0_model", ib.q_d, qm);
    endtask

    task automatic cstep(input logic r, input logic e);
        rst_c = r;
        ic.en = e;
        @(posedge c);
        chist.push_front(cnt);
        void'(chist.pop_back());
`ifdef REG_MUX_STAGE_DELAY_RST_EN
        if (r) foreach (chist[k]) chist[k] = 0;
`endif
        cnt = r ? 0 : (e ? (cnt + 1) % 16 : cnt);
        #1;
        check("cnt_q", ic.q, cnt);
        check("cnt_q_d", ic.q_d, chist[DLY_C-1]);
    endtask

    initial begin
        logic [95:0] rnd;

        // Power-up: hold reset long enough for every chain to carry INIT.
        rst_a = 1'b1;  rst_c = 1'b1;
        ia.en = 1'b0;  ia.sel = '0;  ia.d = TBL;
        ib.en = 1'b0;  ib.sel = '0;  ib.d = TBL;
        ic.en = 1'b0;  ic.sel = 1'b0;
        repeat (4) @(posedge c);
        #1;
        qm = INIT_A;
        hist = '{INIT_A, INIT_A, INIT_A};
        cnt = 0;
        chist = '{0, 0, 0};

        step(1'b1, 1'b0, 2'd0, TBL);
        check("reset_q", ia.q, INIT_A);
        check("reset_q_d", ia.q_d, INIT_A);
        rst_c = 1'b0;

        // Mux sweep: z follows sel in the same cycle.
        for (int s = 0; s < 4; s++) begin
            ia.sel = 2'(s);
            #1;
            case (s)
                0: check("mux_sel0", ia.z, 19'h0F0F0);
                1: check("mux_sel1", ia.z, 19'h15555);
                2: check("mux_sel2", ia.z, 19'h2AAAA);
                default: check("mux_sel3", ia.z, 19'h00000);
            endcase
        end

        // Reset has priority over enable, then first non-reset edge captures.
        step(1'b1, 1'b1, 2'd1, TBL);
        check("rst_prio", ia.q, 19'h00123);
        step(1'b0, 1'b1, 2'd1, TBL);
        check("rst_release_capture", ia.q, 19'h15555);

        // Enable hold while sel toggles.
        step(1'b0, 1'b1, 2'd0, TBL);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 2'((i % 3) + 1), TBL);
            check("hold_q", ia.q, 19'h0F0F0);
        end

        // Delay latency: q_d reaches the captured word exactly DELAY edges after q.
        step(1'b0, 1'b1, 2'd2, TBL);
        check("lat_q", ia.q, 19'h2AAAA);
        for (int k = 1; k <= DLY_A; k++) begin
            step(1'b0, 1'b0, 2'd0, TBL);
            check("lat_q_d", ia.q_d == 19'h2AAAA, k == DLY_A);
        end

        // Reset flush of the delay chain.
        step(1'b1, 1'b0, 2'd0, TBL);
        check("flush_q", ia.q, INIT_A);
        for (int k = 0; k <= DLY_A; k++) begin
`ifdef REG_MUX_STAGE_DELAY_RST_EN
            check("flush_q_d", ia.q_d == INIT_A, 1'b1);
`else
            check("flush_q_d", ia.q_d == INIT_A, k == DLY_A);
`endif
            if (k < DLY_A) step(1'b0, 1'b0, 2'd0, TBL);
        end

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 300; i++) begin
            rnd = {$urandom, $urandom, $urandom};
            step(($urandom % 16) == 0, 1'($urandom), 2'($urandom), rnd[4*DW_A-1:0]);
        end

        // Counter: counts 0..15, wraps, reset at 9 returns to 0.
        for (int i = 1; i <= 20; i++) begin
            cstep(1'b0, 1'b1);
            if (i == 16) check("cnt_wrap", ic.q, 4'h0);
        end
        while (cnt != 9) cstep(1'b0, 1'b1);
        cstep(1'b1, 1'b1);
        check("cnt_rst_at_9", ic.q, 4'h0);
        for (int i = 0; i < 6; i++) cstep(1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
